// File: rtl/led_sequencer.sv
// LED pattern sequencer: IDLE/RUN/PAUSE control with a prescaled tick that
// steps a 4-bit pattern as count-up, count-down, rotate-left or blink.
module led_sequencer #(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic       clock,
   input  logic       n_reset,
   input  logic       cfg_valid,
   input  logic [1:0] cfg_mode,
   output logic       cfg_ready,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] led,
   output logic       tick,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_BAD   = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      M_UP    = 2'b00,
      M_DOWN  = 2'b01,
      M_ROT   = 2'b10,
      M_BLINK = 2'b11
   } mode_t;

   localparam logic [26:0] TERM = 27'(TICK_DIV - 1);

   state_t      cur_state;
   state_t      nxt_state;
   mode_t       mode;
   logic [26:0] prescaler;
   logic        terminal;
   logic        cfg_take;
   logic [3:0]  load_led;
   logic [3:0]  step_led;

   assign cfg_ready = (cur_state == S_IDLE);
   assign state     = cur_state;
   assign cfg_take  = cfg_valid && cfg_ready;
   assign terminal  = (cur_state == S_RUN) && (prescaler == TERM);

   // Pause has priority over start in every state.
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_IDLE:  if (start && !pause) nxt_state = S_RUN;
         S_RUN:   if (pause) nxt_state = S_PAUSE;
         S_PAUSE: begin
            if (pause)      nxt_state = S_IDLE;
            else if (start) nxt_state = S_RUN;
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   always_comb begin
      load_led = 4'b0000;
      case (mode_t'(cfg_mode))
         M_UP:    load_led = 4'b0000;
         M_DOWN:  load_led = 4'b1111;
         M_ROT:   load_led = 4'b0001;
         M_BLINK: load_led = 4'b0000;
         default: load_led = 4'b0000;
      endcase
   end

   always_comb begin
      step_led = led;
      case (mode)
         M_UP:    step_led = led + 4'd1;
         M_DOWN:  step_led = led - 4'd1;
         M_ROT:   step_led = {led[2:0], led[3]};
         M_BLINK: step_led = ~led;
         default: step_led = led;
      endcase
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         cur_state <= S_IDLE;
         mode      <= M_UP;
         led       <= '0;
         tick      <= 1'b0;
         prescaler <= '0;
      end else begin
         cur_state <= nxt_state;
         tick      <= terminal;
         case (cur_state)
            S_RUN:   prescaler <= terminal ? '0 : prescaler + 27'd1;
            S_PAUSE: prescaler <= prescaler;
            default: prescaler <= '0;
         endcase
         if (cfg_take) begin
            mode <= mode_t'(cfg_mode);
            led  <= load_led;
         end else if (terminal) begin
            led <= step_led;
         end
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer (TICK_DIV = 4): reference model compared on
// every falling edge, plus literal checkpoints for the documented sequences.
module tb_led_sequencer;

   localparam int TICK = 4;

   logic       clock;
   logic       n_reset;
   logic       cfg_valid;
   logic [1:0] cfg_mode;
   logic       cfg_ready;
   logic       start;
   logic       pause;
   logic [3:0] led;
   logic       tick;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;
   bit run_chk = 0;

   led_sequencer #(.TICK_DIV(TICK)) dut (
      .clock     (clock),
      .n_reset   (n_reset),
      .cfg_valid (cfg_valid),
      .cfg_mode  (cfg_mode),
      .cfg_ready (cfg_ready),
      .start     (start),
      .pause     (pause),
      .led       (led),
      .tick      (tick),
      .state     (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: state as 0 idle / 1 run / 2 pause, edges counted in RUN.
   int m_state;
   int m_led;
   int m_mode;
   int m_cnt;
   int m_tick;

   function automatic int load_f(input int mode);
      case (mode)
         1:       return 15;
         2:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int step_f(input int mode, input int v);
      case (mode)
         0:       return (v + 1) % 16;
         1:       return (v + 15) % 16;
         2:       return ((v * 2) % 16) + (v / 8);
         default: return 15 - v;
      endcase
   endfunction

   always @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         m_state <= 0;
         m_led   <= 0;
         m_mode  <= 0;
         m_cnt   <= 0;
         m_tick  <= 0;
      end else begin
         m_tick <= 0;
         case (m_state)
            0: begin
               m_cnt <= 0;
               if (cfg_valid) begin
                  m_mode <= int'(cfg_mode);
                  m_led  <= load_f(int'(cfg_mode));
               end
               if (start && !pause) m_state <= 1;
            end
            1: begin
               if (m_cnt + 1 == TICK) begin
                  m_cnt  <= 0;
                  m_tick <= 1;
                  m_led  <= step_f(m_mode, m_led);
               end else begin
                  m_cnt <= m_cnt + 1;
               end
               if (pause) m_state <= 2;
            end
            default: begin
               if (pause)      m_state <= 0;
               else if (start) m_state <= 1;
            end
         endcase
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clock) begin
      if (run_chk && n_reset) begin
         check("model_led",   int'(led),       m_led);
         check("model_tick",  int'(tick),      m_tick);
         check("model_state", int'(state),     m_state);
         check("model_ready", int'(cfg_ready), (m_state == 0) ? 1 : 0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic configure(input logic [1:0] mode);
      cfg_valid = 1'b1;
      cfg_mode  = mode;
      cyc(1);
      cfg_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic to_idle();
      pause = 1'b1;
      cyc(2);
      pause = 1'b0;
   endtask

   initial begin
      n_reset = 1'b0;
      cfg_valid = 1'b0;
      cfg_mode = 2'b00;
      start = 1'b0;
      pause = 1'b0;
      #1;
      check("rst_state", int'(state), 0);
      check("rst_led",   int'(led), 0);
      check("rst_tick",  int'(tick), 0);
      check("rst_ready", int'(cfg_ready), 1);
      #20;
      n_reset = 1'b1;
      cyc(1);
      run_chk = 1;

      // count-up with wrap
      configure(2'b00);
      pulse_start();
      cyc(3);
      check("up_first_tick_early", int'(tick), 0);
      cyc(1);
      check("up_first_tick", int'(tick), 1);
      check("up_first_led", int'(led), 1);
      cyc(59);
      check("up_led_15", int'(led), 15);
      cyc(1);
      check("up_wrap_led", int'(led), 0);
      check("up_wrap_tick", int'(tick), 1);
      to_idle();
      check("up_idle", int'(state), 0);

      // count-down
      configure(2'b01);
      check("down_load", int'(led), 15);
      pulse_start();
      cyc(4);
      check("down_1", int'(led), 14);
      cyc(4);
      check("down_2", int'(led), 13);
      to_idle();

      // rotate-left
      configure(2'b10);
      check("rot_load", int'(led), 1);
      pulse_start();
      cyc(12);
      check("rot_3", int'(led), 8);
      cyc(4);
      check("rot_wrap", int'(led), 1);
      to_idle();

      // pause two cycles after a tick, hold, resume keeps remaining count
      configure(2'b00);
      pulse_start();
      cyc(4);
      cyc(1);
      pause = 1'b1;
      cyc(1);
      pause = 1'b0;
      check("pause_state", int'(state), 2);
      cyc(10);
      check("pause_hold_led", int'(led), 1);
      check("pause_no_tick", int'(tick), 0);
      pulse_start();
      check("resume_state", int'(state), 1);
      cyc(1);
      check("resume_tick_early", int'(tick), 0);
      cyc(1);
      check("resume_tick", int'(tick), 1);
      check("resume_led", int'(led), 2);

      // start+pause together: RUN->PAUSE->IDLE
      start = 1'b1;
      pause = 1'b1;
      cyc(1);
      check("both_pause", int'(state), 2);
      cyc(1);
      check("both_idle", int'(state), 0);
      check("both_ready", int'(cfg_ready), 1);
      check("both_led", int'(led), 2);
      start = 1'b0;
      pause = 1'b0;
      cyc(2);

      // terminal count coinciding with pause
      pulse_start();
      cyc(3);
      pause = 1'b1;
      cyc(1);
      pause = 1'b0;
      check("tc_pause_tick", int'(tick), 1);
      check("tc_pause_led", int'(led), 3);
      check("tc_pause_state", int'(state), 2);
      to_idle();

      // cfg in RUN ignored, then cfg + start in same IDLE cycle
      pulse_start();
      cfg_valid = 1'b1;
      cfg_mode = 2'b11;
      cyc(1);
      check("run_cfg_ready", int'(cfg_ready), 0);
      cyc(3);
      check("run_cfg_led", int'(led), 4);
      cfg_valid = 1'b0;
      to_idle();
      cfg_valid = 1'b1;
      cfg_mode = 2'b11;
      start = 1'b1;
      cyc(1);
      cfg_valid = 1'b0;
      start = 1'b0;
      check("blink_load", int'(led), 0);
      check("blink_run", int'(state), 1);
      cyc(4);
      check("blink_1", int'(led), 15);
      cyc(4);
      check("blink_2", int'(led), 0);
      to_idle();

      // reset mid-count at led 0101, prescaler 2
      configure(2'b00);
      pulse_start();
      cyc(22);
      check("pre_rst_led", int'(led), 5);
      #3;
      n_reset = 1'b0;
      #1;
      check("mid_rst_led", int'(led), 0);
      check("mid_rst_tick", int'(tick), 0);
      check("mid_rst_state", int'(state), 0);
      #12;
      n_reset = 1'b1;
      cyc(10);
      check("post_rst_state", int'(state), 0);
      check("post_rst_led", int'(led), 0);
      pulse_start();
      cyc(4);
      check("post_rst_tick", int'(tick), 1);
      check("post_rst_led1", int'(led), 1);

      run_chk = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
